// File: rtl/csa_stream_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : csa_stream_accumulator (with csa_carry_skip_adder)
// Brief    : Streaming signed accumulator built around a 32-bit carry-skip
//            adder, with sticky overflow, optional saturation and a
//            valid/ready result port.
// Revision : 1.0 - initial release
// ============================================================================

module csa_carry_skip_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             of
);

  localparam int NBLK = WIDTH / BLOCK;

  logic [WIDTH-1:0] w_sum;
  logic             w_c;
  logic             w_bc;
  logic             w_pall;
  logic             w_p;
  logic             w_g;
  logic             w_cmsb;

  // Ripple inside each block; a fully propagating block forwards its carry-in.
  always_comb begin
    w_sum  = '0;
    w_c    = cin;
    w_bc   = 1'b0;
    w_pall = 1'b0;
    w_p    = 1'b0;
    w_g    = 1'b0;
    w_cmsb = 1'b0;
    for (int blk = 0; blk < NBLK; blk++) begin
      w_bc   = w_c;
      w_pall = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
        w_p = a[blk*BLOCK+i] ^ b[blk*BLOCK+i];
        w_g = a[blk*BLOCK+i] & b[blk*BLOCK+i];
        w_sum[blk*BLOCK+i] = w_p ^ w_c;
        if (blk*BLOCK+i == WIDTH-1) begin
          w_cmsb = w_c;
        end
        w_c    = w_g | (w_p & w_c);
        w_pall = w_pall & w_p;
      end
      if (w_pall) begin
        w_c = w_bc;
      end
    end
  end

  assign sum  = w_sum;
  assign cout = w_c;
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign of   = w_cmsb ^ w_c;

endmodule

module csa_stream_accumulator #(
  parameter int SATURATE = 1,
  parameter int LEN_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             out_cout,
  output logic             out_of,
  output logic [LEN_W-1:0] out_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] C_ONE     = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]      C_SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0]      C_SAT_MIN = 32'h8000_0000;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_acc;
  logic             r_cout;
  logic             r_of;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] r_len;

  logic [31:0]      w_b;
  logic [31:0]      w_sum;
  logic             w_cout;
  logic             w_of;
  logic [31:0]      w_next;
  logic             w_accept;
  logic             w_last;

  assign w_b = in_sub ? ~in_data : in_data;

  csa_carry_skip_adder #(
    .WIDTH (32),
    .BLOCK (4)
  ) u_csa (
    .a    (r_acc),
    .b    (w_b),
    .cin  (in_sub),
    .sum  (w_sum),
    .cout (w_cout),
    .of   (w_of)
  );

  // Clamp toward the sign of the running total; that sign decides the overflow direction.
  always_comb begin
    w_next = w_sum;
    if ((SATURATE != 0) && w_of) begin
      w_next = r_acc[31] ? C_SAT_MIN : C_SAT_MAX;
    end
  end

  assign w_accept = (r_state == S_ACCUM) && in_valid;
  assign w_last   = (r_count == (r_len - C_ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (len != '0) ? S_ACCUM : S_DONE;
        end
      end
      S_ACCUM: begin
        if (w_accept && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_cout  <= 1'b0;
      r_of    <= 1'b0;
      r_count <= '0;
      r_len   <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_acc   <= '0;
      r_cout  <= 1'b0;
      r_of    <= 1'b0;
      r_count <= '0;
      r_len   <= len;
    end else if (w_accept) begin
      r_acc   <= w_next;
      r_cout  <= w_cout;
      r_of    <= r_of | w_of;
      r_count <= r_count + C_ONE;
    end
  end

  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_DONE);
  assign out_sum   = r_acc;
  assign out_cout  = r_cout;
  assign out_of    = r_of;
  assign out_count = r_count;

endmodule

`default_nettype wire
